// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: bus widths, FSM state
// encodings, handshake levels and a conditional two's complement helper.
package div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Two's complement of v when en is set, v unchanged otherwise.
    function automatic logic [RegBus-1:0] neg_if(input logic [RegBus-1:0] v, input logic en);
        return en ? (~v + {{(RegBus-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and pick the quotient bit.
module div_step
    import div_pkg::*;
(
    input  logic [RegBus-1:0] rem_i,
    input  logic              bit_i,
    input  logic [RegBus-1:0] divisor_i,
    output logic [RegBus-1:0] rem_o,
    output logic              qbit_o
);

    // The shifted remainder keeps its carry bit so divisors >= 2^31 still
    // compare correctly; the difference itself always fits in 32 bits.
    logic [RegBus:0]   shifted;
    logic [RegBus-1:0] diff;

    // Trial subtract and restore-or-keep selection.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted[RegBus-1:0] - divisor_i;
        qbit_o  = (shifted >= {1'b0, divisor_i});
        rem_o   = qbit_o ? diff : shifted[RegBus-1:0];
    end

endmodule

// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider (DIV/DIVU) answering the EX-stage
// divide handshake; one quotient bit per cycle, result {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: zero divisor short-cuts to a zero result.
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e              state_q;
    logic [4:0]              cnt_q;
    logic [RegBus-1:0]       rem_q;
    logic [RegBus-1:0]       quo_q;
    logic [RegBus-1:0]       divisor_q;
    logic                    neg_quo_q;
    logic                    neg_rem_q;
    logic [DoubleRegBus-1:0] result_q;
    logic                    ready_q;

    logic [RegBus-1:0]       rem_d;
    logic                    qbit_d;
    logic [RegBus-1:0]       quo_d;

    // quo_q starts as the dividend magnitude; its MSB feeds each step and
    // the quotient bits are shifted in from the bottom.
    div_step u_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[RegBus-1]),
        .divisor_i (divisor_q),
        .rem_o     (rem_d),
        .qbit_o    (qbit_d)
    );

    assign quo_d    = {quo_q[RegBus-2:0], qbit_d};
    assign result_o = result_q;
    assign ready_o  = ready_q;

    // Divider FSM: operand latch, 32 iteration steps, sign fix and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DivFree;
            cnt_q    <= 5'd0;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
        end else begin
            case (state_q)
                DivFree: begin
                    result_q <= '0;
                    ready_q  <= DivResultNotReady;
                    if (start_i == DivStart && !annul_i) begin
                        cnt_q     <= 5'd0;
                        rem_q     <= '0;
                        quo_q     <= neg_if(opdata1_i, signed_div_i & opdata1_i[RegBus-1]);
                        divisor_q <= neg_if(opdata2_i, signed_div_i & opdata2_i[RegBus-1]);
                        neg_quo_q <= signed_div_i & (opdata1_i[RegBus-1] ^ opdata2_i[RegBus-1]);
                        neg_rem_q <= signed_div_i & opdata1_i[RegBus-1];
                        state_q   <= DivOn;
`ifdef DIV_ZERO_FAST_EN
                        if (opdata2_i == '0) begin
                            state_q <= DivByZero;
                        end
`endif
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                DivByZero: begin
                    if (annul_i) begin
                        state_q  <= DivFree;
                        result_q <= '0;
                        ready_q  <= DivResultNotReady;
                    end else begin
                        state_q  <= DivEnd;
                        result_q <= '0;
                        ready_q  <= DivResultReady;
                    end
                end
`endif
                DivOn: begin
                    if (annul_i) begin
                        state_q  <= DivFree;
                        result_q <= '0;
                        ready_q  <= DivResultNotReady;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q  <= DivEnd;
                            result_q <= {neg_if(rem_d, neg_rem_q), neg_if(quo_d, neg_quo_q)};
                            ready_q  <= DivResultReady;
                        end
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state_q  <= DivFree;
                        result_q <= '0;
                        ready_q  <= DivResultNotReady;
                    end
                end
                default: begin
                    state_q  <= DivFree;
                    result_q <= '0;
                    ready_q  <= DivResultNotReady;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the iterative divider: directed handshake cases
// plus randomized operands against an arithmetic reference model.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_chk = 0;
    int n_bad = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: {remainder, quotient} from plain integer arithmetic.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
            q = 32'd0;
            r = 32'd0;
`else
            q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
`endif
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                sa = $signed(a);
                sb = $signed(b);
                q  = sa / sb;
                r  = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 2;
`endif
        return 33;
    endfunction

    // Runs one division from a point just after a rising edge; cycle 0 is the
    // current cycle. Optionally holds start in DivEnd and scrambles operands.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int hold, input int chg_cyc);
        logic [63:0] exp;
        int lat;
        exp        = ref_div(sgn, a, b);
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        lat        = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = k;
                break;
            end
            if (k == chg_cyc) begin
                op1        = $urandom;
                op2        = $urandom;
                signed_div = ~signed_div;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_latency(b)));
        chk({tag, "_res"}, result, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_rdy"}, 64'(ready), 64'd1);
            chk({tag, "_hold_res"}, result, exp);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_drop_rdy"}, 64'(ready), 64'd0);
        chk({tag, "_drop_res"}, result, 64'd0);
    endtask

    initial begin
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;
        rst        = 1'b1;
        signed_div = 1'b0;
        op1        = 32'd0;
        op2        = 32'd0;
        start      = 1'b0;
        annul      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 64'(ready), 64'd0);
        chk("rst_res", result, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_div("u100_7", 1'b0, 32'd100, 32'd7, 0, -1);
        do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, -1);
        do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1);
        do_div("u_5_0", 1'b0, 32'd5, 32'd0, 0, -1);
        do_div("s_neg_0", 1'b1, 32'hFFFF_FFF0, 32'd0, 0, -1);
        do_div("u_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0, -1);
        do_div("hold3", 1'b0, 32'd1234567, 32'd89, 3, -1);
        do_div("chg5", 1'b1, 32'hFFFF_0000, 32'd77, 0, 5);

        // Annul mid-division: no ready pulse, outputs stay zero.
        signed_div = 1'b0;
        op1        = 32'd1000;
        op2        = 32'd3;
        start      = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            chk("annul_pre_rdy", 64'(ready), 64'd0);
        end
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("annul_rdy", 64'(ready), 64'd0);
            chk("annul_res", result, 64'd0);
            @(posedge clk); #1;
        end
        do_div("after_annul", 1'b0, 32'd9, 32'd3, 0, -1);

        // Annul while idle keeps start from launching a division.
        start = 1'b1;
        annul = 1'b1;
        op1   = 32'd50;
        op2   = 32'd5;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("idle_annul_rdy", 64'(ready), 64'd0);
        end
        annul = 1'b0;
        do_div("idle_annul_div", 1'b0, 32'd50, 32'd5, 0, -1);

        // Synchronous reset during cycle 15 of a division.
        signed_div = 1'b0;
        op1        = 32'd777;
        op2        = 32'd10;
        start      = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_rdy", 64'(ready), 64'd0);
        chk("midrst_res", result, 64'd0);
        @(posedge clk); #1;
        chk("midrst_idle_rdy", 64'(ready), 64'd0);
        do_div("after_rst", 1'b1, 32'hFFFF_FC00, 32'hFFFF_FFF3, 0, -1);

        // Randomized operands, divisor shape varied to reach edge cases.
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'd0;
                3: rb = ra >> $urandom_range(0, 31);
                default: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            endcase
            do_div("rand", rs, ra, rb, $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 7 : -1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
